// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect/enable controls, icache lookup and refill,
// memory-controller request/response, branch predictor and decoder queue.
//   master : the fetch unit (drives PCs, requests, refills and queue head)
//   slave  : the surrounding environment (icache, mem ctrl, predictor, ROB, decoder)
interface inst_fetch_queue_if #(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  // global control
  logic                  rdy_in;
  logic                  clr_in;
  logic [ADDR_WIDTH-1:0] clr_pc;
  // icache lookup
  logic [ADDR_WIDTH-1:0] ic_fetch_addr;
  logic                  ic_hit;
  logic [31:0]           ic_hit_inst;
  // icache refill
  logic                  ic_upd_valid;
  logic [ADDR_WIDTH-1:0] ic_upd_addr;
  logic [31:0]           ic_upd_inst;
  // memory controller
  logic                  mc_req_valid;
  logic [ADDR_WIDTH-1:0] mc_req_addr;
  logic                  mc_req_ack;
  logic                  mc_resp_valid;
  logic [31:0]           mc_resp_inst;
  // predictor
  logic [ADDR_WIDTH-1:0] pr_pc;
  logic                  pr_taken;
  // decoder queue head
  logic                  dq_valid;
  logic                  dq_ready;
  logic [ADDR_WIDTH-1:0] dq_pc;
  logic [31:0]           dq_inst;
  logic                  dq_pred;
  logic [CNT_W-1:0]      dq_count;

  modport master (
    input  rdy_in, clr_in, clr_pc,
    output ic_fetch_addr,
    input  ic_hit, ic_hit_inst,
    output ic_upd_valid, ic_upd_addr, ic_upd_inst,
    output mc_req_valid, mc_req_addr,
    input  mc_req_ack, mc_resp_valid, mc_resp_inst,
    output pr_pc,
    input  pr_taken,
    output dq_valid, dq_pc, dq_inst, dq_pred, dq_count,
    input  dq_ready
  );

  modport slave (
    output rdy_in, clr_in, clr_pc,
    input  ic_fetch_addr,
    output ic_hit, ic_hit_inst,
    input  ic_upd_valid, ic_upd_addr, ic_upd_inst,
    input  mc_req_valid, mc_req_addr,
    output mc_req_ack, mc_resp_valid, mc_resp_inst,
    input  pr_pc,
    output pr_taken,
    input  dq_valid, dq_pc, dq_inst, dq_pred, dq_count,
    output dq_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: fetches from the icache on a hit, otherwise runs a
// request/ack/response transaction with the memory controller (and refills the
// icache), predicts JAL/branch targets and buffers {PC, inst, pred} in a
// QUEUE_DEPTH-entry FIFO for the decoder. clr_in flushes and redirects.
// Ports:
//   clk_in : clock
//   rst_in : asynchronous active-high reset
//   bus    : inst_fetch_queue_if.master (control, icache, memory, predictor, decoder)
module inst_fetch_queue #(
  parameter int unsigned           QUEUE_DEPTH = 8,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                clk_in,
  input logic                rst_in,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned    PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int unsigned    CNT_W     = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [6:0]     OP_JAL    = 7'b1101111;
  localparam logic [6:0]     OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  mc_req_valid_q, mc_req_valid_d;
  logic [ADDR_WIDTH-1:0] mc_req_addr_q, mc_req_addr_d;
  logic                  ic_upd_valid_q, ic_upd_valid_d;
  logic [ADDR_WIDTH-1:0] ic_upd_addr_q, ic_upd_addr_d;
  logic [31:0]           ic_upd_inst_q, ic_upd_inst_d;

  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
  logic [31:0]           inst_mem [QUEUE_DEPTH];
  logic                  pred_mem [QUEUE_DEPTH];

  logic                  dq_valid;
  logic                  pop;
  logic                  space;
  logic                  push_en;
  logic [31:0]           cur_inst;
  logic                  cur_pred;
  logic [ADDR_WIDTH-1:0] nxt_pc;
  logic [ADDR_WIDTH-1:0] j_off;
  logic [ADDR_WIDTH-1:0] b_off;

  // The instruction being pushed comes from the memory response while a miss
  // is outstanding, and from the icache otherwise.
  always_comb begin
    cur_inst = (state_q == S_RESP) ? bus.mc_resp_inst : bus.ic_hit_inst;
    j_off    = ADDR_WIDTH'($signed({cur_inst[31], cur_inst[19:12], cur_inst[20],
                                    cur_inst[30:21], 1'b0}));
    b_off    = ADDR_WIDTH'($signed({cur_inst[31], cur_inst[7], cur_inst[30:25],
                                    cur_inst[11:8], 1'b0}));
    cur_pred = 1'b0;
    nxt_pc   = pc_q + ADDR_WIDTH'(4);
    case (cur_inst[6:0])
      OP_JAL: begin
        cur_pred = 1'b1;
        nxt_pc   = pc_q + j_off;
      end
      OP_BRANCH: begin
        cur_pred = bus.pr_taken;
        if (bus.pr_taken) nxt_pc = pc_q + b_off;
      end
      default: ;
    endcase
  end

  assign dq_valid = (count_q != '0) && bus.rdy_in;
  assign pop      = dq_valid && bus.dq_ready;
  // An outstanding memory fetch holds a reserved slot, so the response can
  // always be pushed without re-checking occupancy.
  assign space    = ({1'b0, count_q} + {{CNT_W{1'b0}}, (state_q != S_IDLE)}) < DEPTH_EXT;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    mc_req_valid_d = mc_req_valid_q;
    mc_req_addr_d  = mc_req_addr_q;
    ic_upd_valid_d = ic_upd_valid_q;
    ic_upd_addr_d  = ic_upd_addr_q;
    ic_upd_inst_d  = ic_upd_inst_q;
    push_en        = 1'b0;

    if (!bus.rdy_in) begin
      ic_upd_valid_d = 1'b0;
    end else if (bus.clr_in) begin
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      pc_d           = bus.clr_pc;
      ic_upd_valid_d = 1'b0;
      mc_req_valid_d = 1'b0;
      // A request the controller has already taken still owes a response,
      // which must be swallowed in DRAIN.
      case (state_q)
        S_REQ:   state_d = bus.mc_req_ack    ? S_DRAIN : S_IDLE;
        S_RESP:  state_d = bus.mc_resp_valid ? S_IDLE  : S_DRAIN;
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      ic_upd_valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (space) begin
            if (bus.ic_hit) begin
              push_en = 1'b1;
              pc_d    = nxt_pc;
            end else begin
              mc_req_valid_d = 1'b1;
              mc_req_addr_d  = pc_q;
              state_d        = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mc_req_ack) begin
            mc_req_valid_d = 1'b0;
            state_d        = S_RESP;
          end
        end
        S_RESP: begin
          if (bus.mc_resp_valid) begin
            push_en        = 1'b1;
            ic_upd_valid_d = 1'b1;
            ic_upd_addr_d  = pc_q;
            ic_upd_inst_d  = bus.mc_resp_inst;
            pc_d           = nxt_pc;
            state_d        = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (bus.mc_resp_valid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push_en);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      mc_req_valid_q <= 1'b0;
      mc_req_addr_q  <= '0;
      ic_upd_valid_q <= 1'b0;
      ic_upd_addr_q  <= '0;
      ic_upd_inst_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      mc_req_valid_q <= mc_req_valid_d;
      mc_req_addr_q  <= mc_req_addr_d;
      ic_upd_valid_q <= ic_upd_valid_d;
      ic_upd_addr_q  <= ic_upd_addr_d;
      ic_upd_inst_q  <= ic_upd_inst_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_in) begin
    if (push_en) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= cur_inst;
      pred_mem[tail_q] <= cur_pred;
    end
  end

  assign bus.ic_fetch_addr = pc_q;
  assign bus.pr_pc         = pc_q;
  assign bus.ic_upd_valid  = ic_upd_valid_q;
  assign bus.ic_upd_addr   = ic_upd_addr_q;
  assign bus.ic_upd_inst   = ic_upd_inst_q;
  assign bus.mc_req_valid  = mc_req_valid_q;
  assign bus.mc_req_addr   = mc_req_addr_q;
  assign bus.dq_valid      = dq_valid;
  assign bus.dq_pc         = pc_mem[head_q];
  assign bus.dq_inst       = inst_mem[head_q];
  assign bus.dq_pred       = pred_mem[head_q];
  assign bus.dq_count      = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  inst_fetch_queue_if #(.QUEUE_DEPTH(DEPTH), .ADDR_WIDTH(32)) bus ();

  inst_fetch_queue #(.QUEUE_DEPTH(DEPTH), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // stimulus values
  logic        i_rdy, i_clr, i_hit, i_ack, i_resp, i_taken, i_dq_ready;
  logic [31:0] i_clr_pc, i_hit_inst, i_resp_inst;

  // behavioural model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_req_addr, m_upd_addr, m_upd_inst;
  bit          m_req, m_wait, m_drop, m_upd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // {pred, next PC} computed with plain integer offsets
  function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] i,
                                          input logic taken);
    int   off;
    logic p;
    off = 4;
    p   = 1'b0;
    if (i[6:0] == 7'h6F) begin
      p   = 1'b1;
      off = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096
            - (i[31] ? 1048576 : 0);
    end else if (i[6:0] == 7'h63) begin
      p = taken;
      if (taken)
        off = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048
              - (i[31] ? 4096 : 0);
    end
    return {p, pc + 32'(off)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 32'h0; m_req_addr = 32'h0; m_upd_addr = 32'h0; m_upd_inst = 32'h0;
    m_req = 0; m_wait = 0; m_drop = 0; m_upd = 0;
  endtask

  task automatic model_push(input logic [31:0] inst);
    logic [32:0] pn;
    ent_t        e;
    pn     = predict(m_pc, inst, i_taken);
    e.pc   = m_pc;
    e.inst = inst;
    e.pred = pn[32];
    q.push_back(e);
    m_pc = pn[31:0];
  endtask

  task automatic model_step();
    bit pop, busy, space;
    if (!i_rdy) begin
      m_upd = 0;
      return;
    end
    if (i_clr) begin
      q.delete();
      m_pc  = i_clr_pc;
      m_upd = 0;
      if (m_req) begin
        m_req  = 0;
        m_drop = i_ack;
      end else if (m_wait) begin
        m_wait = 0;
        m_drop = !i_resp;
      end
      return;
    end
    m_upd = 0;
    pop   = (q.size() != 0) && i_dq_ready;
    busy  = m_req || m_wait || m_drop;
    space = (q.size() + (busy ? 1 : 0)) < DEPTH;
    if (pop) void'(q.pop_front());
    if (!busy) begin
      if (space) begin
        if (i_hit) model_push(i_hit_inst);
        else begin
          m_req      = 1;
          m_req_addr = m_pc;
        end
      end
    end else if (m_req) begin
      if (i_ack) begin
        m_req  = 0;
        m_wait = 1;
      end
    end else if (m_wait) begin
      if (i_resp) begin
        m_upd      = 1;
        m_upd_addr = m_pc;
        m_upd_inst = i_resp_inst;
        model_push(i_resp_inst);
        m_wait = 0;
      end
    end else if (i_resp) begin
      m_drop = 0;
    end
  endtask

  task automatic check_all();
    chk("ic_fetch_addr", bus.ic_fetch_addr, m_pc);
    chk("pr_pc", bus.pr_pc, m_pc);
    chk("mc_req_valid", bus.mc_req_valid, m_req);
    chk("mc_req_addr", bus.mc_req_addr, m_req_addr);
    chk("ic_upd_valid", bus.ic_upd_valid, m_upd);
    if (m_upd) begin
      chk("ic_upd_addr", bus.ic_upd_addr, m_upd_addr);
      chk("ic_upd_inst", bus.ic_upd_inst, m_upd_inst);
    end
    chk("dq_valid", bus.dq_valid, (q.size() != 0) && i_rdy);
    chk("dq_count", bus.dq_count, q.size());
    if (q.size() != 0) begin
      chk("dq_pc", bus.dq_pc, q[0].pc);
      chk("dq_inst", bus.dq_inst, q[0].inst);
      chk("dq_pred", bus.dq_pred, q[0].pred);
    end
  endtask

  task automatic drive();
    bus.rdy_in        = i_rdy;
    bus.clr_in        = i_clr;
    bus.clr_pc        = i_clr_pc;
    bus.ic_hit        = i_hit;
    bus.ic_hit_inst   = i_hit_inst;
    bus.mc_req_ack    = i_ack;
    bus.mc_resp_valid = i_resp;
    bus.mc_resp_inst  = i_resp_inst;
    bus.pr_taken      = i_taken;
    bus.dq_ready      = i_dq_ready;
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic tick();
    drive();
    #1;
    check_all();
    model_step();
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {r[31:7], 7'h13};
      1:       return {r[31:7], 7'h6F};
      2:       return {r[31:7], 7'h63};
      default: return {r[31:7], 7'h67};
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ready_bias;
    rst_in = 1'b1;
    i_rdy = 1; i_clr = 0; i_hit = 0; i_ack = 0; i_resp = 0; i_taken = 0; i_dq_ready = 0;
    i_clr_pc = 0; i_hit_inst = 32'h13; i_resp_inst = 32'h13;
    drive();
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // reset state
    chk("rst_dq_count", bus.dq_count, 0);
    chk("rst_mc_req_valid", bus.mc_req_valid, 0);
    chk("rst_mc_req_addr", bus.mc_req_addr, 0);
    chk("rst_pc", bus.ic_fetch_addr, 0);

    // hits fill the queue in order, then fetch stalls
    i_hit = 1; i_hit_inst = 32'h0000_0013;
    repeat (3) tick();
    chk("fill3_count", bus.dq_count, 3);
    chk("fill3_head_pc", bus.dq_pc, 0);
    chk("fill3_pred", bus.dq_pred, 0);
    repeat (7) tick();
    chk("full_count", bus.dq_count, 8);
    chk("full_pc_frozen", bus.ic_fetch_addr, 32'h20);

    // pop from full: space is judged on pre-pop occupancy, push follows next cycle
    i_dq_ready = 1;
    tick();
    chk("pop_full_count", bus.dq_count, 7);
    chk("pop_full_head", bus.dq_pc, 32'h4);
    i_dq_ready = 0;
    tick();
    chk("refill_count", bus.dq_count, 8);
    chk("refill_pc", bus.ic_fetch_addr, 32'h24);
    i_dq_ready = 1;
    repeat (20) tick();
    i_dq_ready = 0;

    // miss at 0x100, JAL +8 response
    i_clr = 1; i_clr_pc = 32'h100; i_hit = 0;
    tick();
    i_clr = 0;
    tick();
    chk("miss_req_valid", bus.mc_req_valid, 1);
    chk("miss_req_addr", bus.mc_req_addr, 32'h100);
    repeat (2) tick();
    i_ack = 1;
    tick();
    i_ack = 0;
    chk("miss_acked", bus.mc_req_valid, 0);
    repeat (2) tick();
    i_resp = 1; i_resp_inst = 32'h0080_006F;
    tick();
    i_resp = 0;
    chk("miss_upd_valid", bus.ic_upd_valid, 1);
    chk("miss_upd_addr", bus.ic_upd_addr, 32'h100);
    chk("miss_upd_inst", bus.ic_upd_inst, 32'h0080_006F);
    chk("miss_dq_pc", bus.dq_pc, 32'h100);
    chk("miss_dq_pred", bus.dq_pred, 1);
    chk("miss_next_pc", bus.ic_fetch_addr, 32'h108);
    i_hit = 1; i_hit_inst = 32'h13;
    tick();
    chk("upd_pulse_end", bus.ic_upd_valid, 0);

    // BEQ -16 at 0x40, taken then not taken
    i_clr = 1; i_clr_pc = 32'h40;
    tick();
    i_clr = 0; i_hit_inst = 32'hFE00_08E3; i_taken = 1;
    tick();
    chk("beq_t_pred", bus.dq_pred, 1);
    chk("beq_t_pc", bus.dq_pc, 32'h40);
    chk("beq_t_next", bus.ic_fetch_addr, 32'h30);
    i_clr = 1;
    tick();
    i_clr = 0; i_taken = 0;
    tick();
    chk("beq_nt_pred", bus.dq_pred, 0);
    chk("beq_nt_next", bus.ic_fetch_addr, 32'h44);
    i_hit_inst = 32'h13;

    // flush during RESP, response two cycles later is dropped
    i_clr = 1; i_clr_pc = 32'h300; i_hit = 0;
    tick();
    i_clr = 0;
    tick();
    i_ack = 1;
    tick();
    i_ack = 0;
    i_clr = 1; i_clr_pc = 32'h200;
    tick();
    i_clr = 0;
    tick();
    i_resp = 1; i_resp_inst = 32'h0080_006F;
    tick();
    i_resp = 0;
    chk("drain_no_upd", bus.ic_upd_valid, 0);
    chk("drain_empty", bus.dq_count, 0);
    tick();
    chk("redirect_req", bus.mc_req_valid, 1);
    chk("redirect_addr", bus.mc_req_addr, 32'h200);

    // async reset in REQ with a non-empty queue
    i_ack = 1;
    tick();
    i_ack = 0; i_resp = 1; i_resp_inst = 32'h13;
    tick();
    i_resp = 0; i_hit = 1;
    repeat (2) tick();
    i_hit = 0;
    tick();
    chk("pre_rst_req", bus.mc_req_valid, 1);
    chk("pre_rst_count", bus.dq_count, 3);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_req", bus.mc_req_valid, 0);
    chk("async_rst_count", bus.dq_count, 0);
    chk("async_rst_pc", bus.ic_fetch_addr, 0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;

    // rdy_in low freezes everything
    i_hit = 1;
    repeat (2) tick();
    i_rdy = 0; i_dq_ready = 1;
    repeat (5) begin
      tick();
      chk("rdy0_dq_valid", bus.dq_valid, 0);
    end
    chk("rdy0_count", bus.dq_count, 2);
    chk("rdy0_pc", bus.ic_fetch_addr, 32'h8);
    i_rdy = 1; i_dq_ready = 0;

    // randomized traffic
    ready_bias = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ready_bias = $urandom_range(0, 3);
      i_rdy       = ($urandom_range(0, 9) != 0);
      i_clr       = ($urandom_range(0, 39) == 0);
      i_clr_pc    = $urandom & 32'hFFFF_FFFC;
      i_hit       = ($urandom_range(0, 2) != 0);
      i_hit_inst  = gen_inst();
      i_taken     = $urandom_range(0, 1) != 0;
      i_dq_ready  = ($urandom_range(0, 3) < ready_bias);
      i_ack       = m_req && ($urandom_range(0, 2) == 0);
      i_resp      = (m_wait || m_drop) && ($urandom_range(0, 2) == 0);
      i_resp_inst = gen_inst();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
